// File: rtl/rv32_types.sv
// Shared rv32 pipeline types: memory-op encoding (shared with writeback),
// data-memory FSM states, and the execute->mem / mem->wb buffer structs.
package rv32_types;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LH,
    MEM_LW,
    MEM_LBU,
    MEM_LHU,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic {
    DMEM_IDLE,
    DMEM_WAIT_GNT
  } dmem_state_t;

  typedef struct packed {
    mem_op_t    mem_op;
    logic [4:0] rd;
    logic       register_wb;
  } decoded_instr_t;

  typedef struct packed {
    logic           valid;
    logic [31:0]    pc;
    decoded_instr_t decoded_instr;
    logic [31:0]    alu_result;
    logic [31:0]    mem_addr;
    logic [31:0]    rs2_data;
  } exec_mem_buffer_t;

  // byte_off is kept so writeback can extract/extend the loaded lane.
  typedef struct packed {
    logic        valid;
    logic        register_wb;
    logic [4:0]  rd;
    mem_op_t     mem_op;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [1:0]  byte_off;
  } mem_wb_buffer_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Builds the writeback record; kill_wb suppresses the register write.
  function automatic mem_wb_buffer_t to_wb(input logic valid, input logic [31:0] pc,
                                           input decoded_instr_t di, input logic [31:0] alu,
                                           input logic [1:0] off, input logic kill_wb);
    mem_wb_buffer_t w;
    w             = '0;
    w.valid       = valid;
    w.register_wb = di.register_wb & ~kill_wb;
    w.rd          = di.rd;
    w.mem_op      = di.mem_op;
    w.pc          = pc;
    w.alu_result  = alu;
    w.byte_off    = off;
    return w;
  endfunction

endpackage

// File: rtl/rv32_store_align.sv
// Store lane alignment: mem_op + byte offset + rs2 -> byte enables, replicated
// write data and a natural-alignment violation flag. Lanes below the byte
// offset are masked off, so a misaligned access degrades to an in-word partial.
module rv32_store_align
  import rv32_types::*;
(
  input  mem_op_t     mem_op_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  logic [3:0] lane_mask;
  assign lane_mask = 4'hF << byte_off_i;

  // Lane selection and data replication per access size.
  always_comb begin
    be_o         = 4'h0;
    wdata_o      = rs2_i;
    misaligned_o = 1'b0;
    case (mem_op_i)
      MEM_SB: begin
        be_o    = 4'b0001 << byte_off_i;
        wdata_o = {4{rs2_i[7:0]}};
      end
      MEM_SH: begin
        be_o         = (4'b0011 << {byte_off_i[1], 1'b0}) & lane_mask;
        wdata_o      = {2{rs2_i[15:0]}};
        misaligned_o = byte_off_i[0];
      end
      MEM_SW: begin
        be_o         = lane_mask;
        misaligned_o = |byte_off_i;
      end
      MEM_LB, MEM_LBU: be_o = 4'hF;
      MEM_LH, MEM_LHU: begin
        be_o         = 4'hF;
        misaligned_o = byte_off_i[0];
      end
      MEM_LW: begin
        be_o         = 4'hF;
        misaligned_o = |byte_off_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_mem_stage.sv
// rv32 memory stage: issues dmem req/gnt transactions, holds the request
// stable while waiting for grant (stalling upstream and inserting bubbles),
// and registers the instruction into mem_wb_buff.
// Optional: RV32_MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and
// reports them on misalign_trap/misalign_addr instead.
module rv32_mem_stage
  import rv32_types::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  exec_mem_buffer_t       exec_mem_buff,
  output mem_wb_buffer_t         mem_wb_buff,
  output logic                   mem_stall,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [3:0]             dmem_be,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_gnt,
  output logic [STALL_CNT_W-1:0] dmem_stall_cnt
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  ,
  output logic                   misalign_trap,
  output logic [31:0]            misalign_addr
`endif
);

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  dmem_state_t              state_q, state_d;
  mem_wb_buffer_t           wb_q, wb_d;
  mem_wb_buffer_t           hold_wb_q, hold_wb_d;
  logic                     hold_we_q, hold_we_d;
  logic [3:0]               hold_be_q, hold_be_d;
  logic [31:0]              hold_addr_q, hold_addr_d;
  logic [31:0]              hold_wdata_q, hold_wdata_d;
  logic [STALL_CNT_W-1:0]   cnt_q, cnt_d;

  mem_op_t     in_op;
  logic        in_mem, in_trap, in_req;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_mis;
  logic        req_raw;
  mem_wb_buffer_t in_wb;

  assign in_op   = exec_mem_buff.decoded_instr.mem_op;
  assign in_mem  = exec_mem_buff.valid && (in_op != MEM_NONE);
  assign in_trap = TrapEn && in_mem && al_mis;
  assign in_req  = in_mem && !in_trap;
  assign in_wb   = to_wb(exec_mem_buff.valid, exec_mem_buff.pc, exec_mem_buff.decoded_instr,
                         exec_mem_buff.alu_result, exec_mem_buff.mem_addr[1:0], in_trap);

  rv32_store_align u_align (
    .mem_op_i    (in_op),
    .byte_off_i  (exec_mem_buff.mem_addr[1:0]),
    .rs2_i       (exec_mem_buff.rs2_data),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .misaligned_o(al_mis)
  );

  // Next-state, request drive and writeback selection.
  always_comb begin
    state_d      = state_q;
    wb_d         = '0;
    hold_wb_d    = hold_wb_q;
    hold_we_d    = hold_we_q;
    hold_be_d    = hold_be_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    req_raw      = 1'b0;
    dmem_we      = 1'b0;
    dmem_be      = 4'h0;
    dmem_addr    = 32'h0;
    dmem_wdata   = 32'h0;
    mem_stall    = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (exec_mem_buff.valid) wb_d = in_wb;
        if (in_req) begin
          req_raw    = 1'b1;
          dmem_we    = is_store(in_op);
          dmem_be    = al_be;
          dmem_addr  = {exec_mem_buff.mem_addr[31:2], 2'b00};
          dmem_wdata = al_wdata;
          if (!dmem_gnt) begin
            state_d      = DMEM_WAIT_GNT;
            mem_stall    = 1'b1;
            wb_d         = '0;
            hold_wb_d    = in_wb;
            hold_we_d    = is_store(in_op);
            hold_be_d    = al_be;
            hold_addr_d  = {exec_mem_buff.mem_addr[31:2], 2'b00};
            hold_wdata_d = al_wdata;
          end
        end
      end
      DMEM_WAIT_GNT: begin
        req_raw    = 1'b1;
        dmem_we    = hold_we_q;
        dmem_be    = hold_be_q;
        dmem_addr  = hold_addr_q;
        dmem_wdata = hold_wdata_q;
        if (dmem_gnt) begin
          state_d = DMEM_IDLE;
          wb_d    = hold_wb_q;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // Request is forced low while reset is asserted, without waiting for a clock.
  assign dmem_req = req_raw && resetn;

  // Saturating grant-wait counter.
  always_comb begin
    cnt_d = cnt_q;
    if (dmem_req && !dmem_gnt && (cnt_q != {STALL_CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // State, writeback buffer, hold registers and counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= DMEM_IDLE;
      wb_q         <= '0;
      hold_wb_q    <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= 4'h0;
      hold_addr_q  <= 32'h0;
      hold_wdata_q <= 32'h0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wb_q         <= wb_d;
      hold_wb_q    <= hold_wb_d;
      hold_we_q    <= hold_we_d;
      hold_be_q    <= hold_be_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_wb_buff    = wb_q;
  assign dmem_stall_cnt = cnt_q;

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  logic        trap_q;
  logic [31:0] trap_addr_q;

  // One-cycle trap pulse aligned with the trapping instruction reaching writeback.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trap_q      <= 1'b0;
      trap_addr_q <= 32'h0;
    end else begin
      trap_q      <= in_trap && (state_q == DMEM_IDLE);
      trap_addr_q <= (in_trap && (state_q == DMEM_IDLE)) ? exec_mem_buff.mem_addr : 32'h0;
    end
  end

  assign misalign_trap = trap_q;
  assign misalign_addr = trap_addr_q;
`endif

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Directed bench for rv32_mem_stage: grant handshake, store alignment,
// bubbles/stall, async reset mid-wait, counter saturation (4-bit instance).
module tb_rv32_mem_stage;
  import rv32_types::*;

  logic             clk = 1'b0;
  logic             resetn;
  exec_mem_buffer_t em;
  logic             gnt;

  mem_wb_buffer_t wb, wb4;
  logic           stall, stall4, req, req4, we, we4;
  logic [3:0]     be, be4;
  logic [31:0]    addr, addr4, wdata, wdata4;
  logic [31:0]    cnt;
  logic [3:0]     cnt4;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  logic           trap, trap4;
  logic [31:0]    taddr, taddr4;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_mem_stage #(.STALL_CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .exec_mem_buff(em), .mem_wb_buff(wb), .mem_stall(stall),
    .dmem_req(req), .dmem_we(we), .dmem_be(be), .dmem_addr(addr), .dmem_wdata(wdata),
    .dmem_gnt(gnt), .dmem_stall_cnt(cnt)
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    , .misalign_trap(trap), .misalign_addr(taddr)
`endif
  );

  rv32_mem_stage #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .exec_mem_buff(em), .mem_wb_buff(wb4), .mem_stall(stall4),
    .dmem_req(req4), .dmem_we(we4), .dmem_be(be4), .dmem_addr(addr4), .dmem_wdata(wdata4),
    .dmem_gnt(gnt), .dmem_stall_cnt(cnt4)
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    , .misalign_trap(trap4), .misalign_addr(taddr4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input mem_op_t op, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd, input logic rwb);
    em                           = '0;
    em.valid                     = v;
    em.pc                        = 32'h1000;
    em.decoded_instr.mem_op      = op;
    em.decoded_instr.rd          = rd;
    em.decoded_instr.register_wb = rwb;
    em.alu_result                = a;
    em.mem_addr                  = a;
    em.rs2_data                  = d;
  endtask

  initial begin
    resetn = 1'b0;
    em     = '0;
    gnt    = 1'b0;

    // reset state
    #12;
    chk("rst_wb_valid", 32'(wb.valid), 32'd0);
    chk("rst_wb_rwb", 32'(wb.register_wb), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    resetn = 1'b1;

    // 1: SW granted immediately
    drive(1'b1, MEM_SW, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0);
    gnt = 1'b1;
    #1;
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_we", 32'(we), 32'd1);
    chk("t1_be", 32'(be), 32'hF);
    chk("t1_addr", addr, 32'h100);
    chk("t1_wdata", wdata, 32'hDEADBEEF);
    chk("t1_stall", 32'(stall), 32'd0);
    tick();
    chk("t1_wb_valid", 32'(wb.valid), 32'd1);
    chk("t1_wb_op", 32'(wb.mem_op), 32'(MEM_SW));
    chk("t1_cnt", cnt, 32'd0);

    // 2: SB @0x103, grant withheld 3 cycles
    drive(1'b1, MEM_SB, 32'h103, 32'h1234565A, 5'd0, 1'b0);
    gnt = 1'b0;
    #1;
    chk("t2_req", 32'(req), 32'd1);
    chk("t2_be", 32'(be), 32'h8);
    chk("t2_addr", addr, 32'h100);
    chk("t2_wdata", wdata, 32'h5A5A5A5A);
    chk("t2_stall", 32'(stall), 32'd1);
    tick();
    chk("t2_bubble0", 32'(wb.valid), 32'd0);
    chk("t2_cnt1", cnt, 32'd1);
    // upstream fields change: request must come from the hold registers
    drive(1'b0, MEM_SW, 32'h3FC, 32'h0, 5'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_wait_stall", 32'(stall), 32'd1);
      chk("t2_wait_be", 32'(be), 32'h8);
      chk("t2_wait_addr", addr, 32'h100);
      chk("t2_wait_wdata", wdata, 32'h5A5A5A5A);
      tick();
      chk("t2_wait_bubble", 32'(wb.valid), 32'd0);
      chk("t2_wait_cnt", cnt, 32'(i + 2));
    end
    gnt = 1'b1;
    #1;
    chk("t2_gnt_stall", 32'(stall), 32'd0);
    chk("t2_gnt_req", 32'(req), 32'd1);
    chk("t2_gnt_wdata", wdata, 32'h5A5A5A5A);
    tick();
    chk("t2_wb_valid", 32'(wb.valid), 32'd1);
    chk("t2_wb_op", 32'(wb.mem_op), 32'(MEM_SB));
    chk("t2_wb_off", 32'(wb.byte_off), 32'd3);
    chk("t2_cnt", cnt, 32'd3);

    // 3: LW granted, then a non-memory op right behind it
    drive(1'b1, MEM_LW, 32'h200, 32'h0, 5'd5, 1'b1);
    #1;
    chk("t3_req", 32'(req), 32'd1);
    chk("t3_we", 32'(we), 32'd0);
    chk("t3_be", 32'(be), 32'hF);
    chk("t3_addr", addr, 32'h200);
    tick();
    chk("t3_lw_wb_valid", 32'(wb.valid), 32'd1);
    chk("t3_lw_wb_rd", 32'(wb.rd), 32'd5);
    drive(1'b1, MEM_NONE, 32'h55, 32'h0, 5'd6, 1'b1);
    gnt = 1'b0;
    #1;
    chk("t3_add_req", 32'(req), 32'd0);
    chk("t3_add_stall", 32'(stall), 32'd0);
    tick();
    chk("t3_add_wb_valid", 32'(wb.valid), 32'd1);
    chk("t3_add_wb_rd", 32'(wb.rd), 32'd6);
    chk("t3_add_wb_alu", wb.alu_result, 32'h55);
    chk("t3_cnt", cnt, 32'd3);

    // 4: reset while waiting for grant
    drive(1'b1, MEM_SW, 32'h300, 32'h11, 5'd0, 1'b0);
    tick();
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("t4_wait_req", 32'(req), 32'd1);
    chk("t4_wait_cnt", cnt, 32'd4);
    resetn = 1'b0;
    #1;
    chk("t4_rst_req", 32'(req), 32'd0);
    chk("t4_rst_wb_valid", 32'(wb.valid), 32'd0);
    chk("t4_rst_cnt", cnt, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("t4_no_replay_req", 32'(req), 32'd0);
    chk("t4_no_replay_wb", 32'(wb.valid), 32'd0);
    chk("t4_no_replay_stall", 32'(stall), 32'd0);

    // 5: 20 cycles without grant; 4-bit counter saturates
    drive(1'b1, MEM_SW, 32'h400, 32'h1, 5'd0, 1'b0);
    repeat (20) tick();
    chk("t5_cnt4_sat", 32'(cnt4), 32'd15);
    chk("t5_cnt32", cnt, 32'd20);
    chk("t5_req_held", 32'(req), 32'd1);
    gnt = 1'b1;
    #1;
    chk("t5_gnt_stall", 32'(stall), 32'd0);
    tick();
    chk("t5_wb_valid", 32'(wb.valid), 32'd1);
    chk("t5_cnt4_hold", 32'(cnt4), 32'd15);

    // 6: halfword/word alignment boundaries
    drive(1'b1, MEM_SH, 32'h102, 32'h0000ABCD, 5'd0, 1'b0);
    #1;
    chk("t6_sh2_be", 32'(be), 32'hC);
    chk("t6_sh2_wdata", wdata, 32'hABCDABCD);
    tick();
    drive(1'b1, MEM_SH, 32'h101, 32'h0000ABCD, 5'd0, 1'b0);
    #1;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
    chk("t6_trap_req", 32'(req), 32'd0);
    chk("t6_trap_stall", 32'(stall), 32'd0);
    tick();
    chk("t6_trap", 32'(trap), 32'd1);
    chk("t6_trap_addr", taddr, 32'h101);
    chk("t6_trap_wb_valid", 32'(wb.valid), 32'd1);
    chk("t6_trap_wb_rwb", 32'(wb.register_wb), 32'd0);
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("t6_trap_pulse", 32'(trap), 32'd0);
`else
    chk("t6_sh1_req", 32'(req), 32'd1);
    chk("t6_sh1_be", 32'(be), 32'h2);
    chk("t6_sh1_addr", addr, 32'h100);
    chk("t6_sh1_wdata", wdata, 32'hABCDABCD);
    tick();
    chk("t6_sh1_wb_valid", 32'(wb.valid), 32'd1);
    drive(1'b1, MEM_SW, 32'h103, 32'hCAFEF00D, 5'd0, 1'b0);
    #1;
    chk("t6_sw3_be", 32'(be), 32'h8);
    chk("t6_sw3_addr", addr, 32'h100);
    tick();
    drive(1'b1, MEM_SB, 32'h101, 32'h000000C3, 5'd0, 1'b0);
    #1;
    chk("t6_sb1_be", 32'(be), 32'h2);
    chk("t6_sb1_wdata", wdata, 32'hC3C3C3C3);
    tick();
`endif
    drive(1'b0, MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    gnt = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
